// File: rtl/div_pkg.sv
// Shared definitions for the divider issue controller.
//   - Op encodings (funct3[1:0] of DIV/DIVU/REM/REMU)
//   - Divider depth and data width
//   - Shadow pipeline entry layout (everything except the tag, whose width
//     is a parameter of the top)
//   - Small helpers for op decode and 32-bit magnitude
package div_pkg;

  localparam int DIV_XLEN    = 32;
  localparam int DIV_OP_W    = 2;
  localparam int DIV_LATENCY = 8;

  localparam logic [DIV_OP_W-1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [DIV_OP_W-1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [DIV_OP_W-1:0] DIV_OP_REM  = 2'b10;
  localparam logic [DIV_OP_W-1:0] DIV_OP_REMU = 2'b11;

  // Per-op fixup information carried alongside the divider data.
  typedef struct packed {
    logic [DIV_OP_W-1:0] op;
    logic                neg_q;
    logic                neg_r;
    logic                dz;
  } div_shadow_t;

  // Bit 0 of the op selects the unsigned flavour.
  function automatic logic is_signed_op(input logic [DIV_OP_W-1:0] op);
    return !op[0];
  endfunction

  // Bit 1 of the op selects remainder instead of quotient.
  function automatic logic is_rem_op(input logic [DIV_OP_W-1:0] op);
    return op[1];
  endfunction

  // Unsigned magnitude of a two's-complement value. 0x8000_0000 maps to
  // itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_XLEN-1:0] mag32(input logic [DIV_XLEN-1:0] x);
    return x[DIV_XLEN-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/DividerUnsignedPipelined.sv
// 8-stage unsigned restoring divider, 4 quotient bits resolved per stage.
//   clk, rst          clock, synchronous active-high reset
//   stall             hold every stage register
//   i_dividend/i_divisor   operands, captured into stage 1
//   o_quotient/o_remainder result of the op in stage 8
// Division by zero yields quotient all-ones and remainder equal to the
// dividend, which falls out of the restoring recurrence naturally.
module DividerUnsignedPipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  localparam int STAGES = 8;
  localparam int BITS   = 32 / STAGES;

  // The dividend register shifts quotient bits in at the bottom as the
  // dividend bits shift out the top, so it ends up holding the quotient.
  logic [31:0] dvd_reg [1:STAGES];
  logic [31:0] rem_reg [1:STAGES];
  logic [31:0] dvs_reg [1:STAGES-1];

  logic [31:0] dvd_in  [0:STAGES-1];
  logic [31:0] rem_in  [0:STAGES-1];
  logic [31:0] dvs_in  [0:STAGES-1];
  logic [31:0] dvd_out [0:STAGES-1];
  logic [31:0] rem_out [0:STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage_in
      if (gi == 0) begin : g_first
        assign dvd_in[gi] = i_dividend;
        assign rem_in[gi] = '0;
        assign dvs_in[gi] = i_divisor;
      end else begin : g_rest
        assign dvd_in[gi] = dvd_reg[gi];
        assign rem_in[gi] = rem_reg[gi];
        assign dvs_in[gi] = dvs_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    logic [32:0] r_v;
    logic [31:0] d_v;
    for (int s = 0; s < STAGES; s++) begin
      r_v = {1'b0, rem_in[s]};
      d_v = dvd_in[s];
      for (int k = 0; k < BITS; k++) begin
        r_v = {r_v[31:0], d_v[31]};
        d_v = {d_v[30:0], 1'b0};
        if (r_v >= {1'b0, dvs_in[s]}) begin
          r_v    = r_v - {1'b0, dvs_in[s]};
          d_v[0] = 1'b1;
        end
      end
      rem_out[s] = r_v[31:0];
      dvd_out[s] = d_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 1; s <= STAGES; s++) begin
        dvd_reg[s] <= '0;
        rem_reg[s] <= '0;
      end
      for (int s = 1; s < STAGES; s++) begin
        dvs_reg[s] <= '0;
      end
    end else if (!stall) begin
      for (int s = 0; s < STAGES; s++) begin
        dvd_reg[s+1] <= dvd_out[s];
        rem_reg[s+1] <= rem_out[s];
      end
      for (int s = 0; s < STAGES-1; s++) begin
        dvs_reg[s+1] <= dvs_in[s];
      end
    end
  end

  assign o_quotient  = dvd_reg[STAGES];
  assign o_remainder = rem_reg[STAGES];

endmodule

// File: rtl/div_sign_fix.sv
// Combinational RISC-V result fixup for the unsigned divider output.
//   op           DIV/DIVU/REM/REMU
//   q, r         unsigned quotient / remainder of the magnitudes
//   neg_q/neg_r  re-sign quotient / remainder
//   dz           divisor was zero
//   result       architectural result
// Signed overflow (-2^31 / -1) needs no special case: the magnitudes give
// q = 0x8000_0000 with neg_q = 0 and r = 0.
module div_sign_fix
  import div_pkg::*;
(
  input  logic [DIV_OP_W-1:0] op,
  input  logic [DIV_XLEN-1:0] q,
  input  logic [DIV_XLEN-1:0] r,
  input  logic                neg_q,
  input  logic                neg_r,
  input  logic                dz,
  output logic [DIV_XLEN-1:0] result
);

  always_comb begin
    result = q;
    if (is_rem_op(op)) begin
      // Divide-by-zero remainder is |a| from the divider; re-signing it
      // with neg_r restores the original dividend.
      result = neg_r ? (~r + 1'b1) : r;
    end else if (dz) begin
      result = '1;
    end else begin
      result = neg_q ? (~q + 1'b1) : q;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/sequencing control around the 8-stage unsigned pipelined divider.
// Accepts DIV/DIVU/REM/REMU requests, feeds operand magnitudes to the
// divider, tracks each op in a shadow pipeline that moves in lockstep with
// the divider, stalls everything on result backpressure and applies the
// RISC-V sign and divide-by-zero fixups on the way out.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop every in-flight op (and any same-cycle accept)
//   in_valid/in_ready    request handshake; in_op, in_a, in_b, in_tag
//   out_valid/out_ready  result handshake; out_result, out_tag
//   perf_ops, perf_stall (only with DIV_PERF_CNT_EN) completed ops and
//                        stalled cycles, free-running 32-bit counters
//
// Build option: define DIV_PERF_CNT_EN to add the performance counters.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int LATENCY = DIV_LATENCY  // must match the divider depth
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIV_OP_W-1:0] in_op,
  input  logic [DIV_XLEN-1:0] in_a,
  input  logic [DIV_XLEN-1:0] in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIV_XLEN-1:0] out_result,
  output logic [TAG_W-1:0]    out_tag
`ifdef DIV_PERF_CNT_EN
  ,
  output logic [31:0]         perf_ops,
  output logic [31:0]         perf_stall
`endif
);

  logic                stall;
  logic                accept;
  logic                signed_op;
  logic [DIV_XLEN-1:0] div_a;
  logic [DIV_XLEN-1:0] div_b;
  logic [DIV_XLEN-1:0] div_q;
  logic [DIV_XLEN-1:0] div_r;
  div_shadow_t         sh_new;

  logic [LATENCY:1]    vld_reg;
  div_shadow_t         sh_reg  [1:LATENCY];
  logic [TAG_W-1:0]    tag_reg [1:LATENCY];

  assign stall     = vld_reg[LATENCY] && !out_ready;
  assign in_ready  = !stall;
  assign accept    = in_valid && in_ready;
  assign signed_op = is_signed_op(in_op);

  // Bubbles enter the divider as zeros so idle stages stay quiet.
  assign div_a = accept ? (signed_op ? mag32(in_a) : in_a) : '0;
  assign div_b = accept ? (signed_op ? mag32(in_b) : in_b) : '0;

  always_comb begin
    sh_new.op    = in_op;
    sh_new.dz    = (in_b == '0);
    sh_new.neg_q = signed_op && (in_a[DIV_XLEN-1] ^ in_b[DIV_XLEN-1]) && (in_b != '0);
    sh_new.neg_r = signed_op && in_a[DIV_XLEN-1];
  end

  DividerUnsignedPipelined u_divider (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .i_dividend  (div_a),
    .i_divisor   (div_b),
    .o_quotient  (div_q),
    .o_remainder (div_r)
  );

  // Shadow pipeline: valid bits plus the per-op fixup info and tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
      for (int k = 1; k <= LATENCY; k++) begin
        sh_reg[k]  <= '0;
        tag_reg[k] <= '0;
      end
    end else begin
      if (!stall) begin
        vld_reg    <= {vld_reg[LATENCY-1:1], accept};
        sh_reg[1]  <= sh_new;
        tag_reg[1] <= in_tag;
        for (int k = LATENCY; k >= 2; k--) begin
          sh_reg[k]  <= sh_reg[k-1];
          tag_reg[k] <= tag_reg[k-1];
        end
      end
      // Flush wins over both advance and hold; clearing the last stage
      // also releases a pending stall on the following cycle.
      if (flush) begin
        vld_reg <= '0;
      end
    end
  end

  div_sign_fix u_sign_fix (
    .op     (sh_reg[LATENCY].op),
    .q      (div_q),
    .r      (div_r),
    .neg_q  (sh_reg[LATENCY].neg_q),
    .neg_r  (sh_reg[LATENCY].neg_r),
    .dz     (sh_reg[LATENCY].dz),
    .result (out_result)
  );

  assign out_valid = vld_reg[LATENCY];
  assign out_tag   = tag_reg[LATENCY];

`ifdef DIV_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready) perf_ops <= perf_ops + 32'd1;
      if (stall)                  perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: a queue-based model predicts every output each
// cycle from the request stream, and directed cases pin literal results,
// latency, backpressure, flush and reset behaviour.
module tb_div_issue_ctrl;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_a, in_b, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
`ifdef DIV_PERF_CNT_EN
  logic [31:0]      perf_ops, perf_stall;
`endif

  always #5 clk = ~clk;

  div_issue_ctrl #(.TAG_W(TAG_W), .LATENCY(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
`ifdef DIV_PERF_CNT_EN
    ,
    .perf_ops   (perf_ops),
    .perf_stall (perf_stall)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural RISC-V M-extension result, straight from the ISA rules.
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int  sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Model: each accepted op remembers how many pipeline advances had
  // happened when it entered; it is presented once 8 advances have passed.
  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    int               acc;
  } exp_t;

  exp_t        mq[$];
  int          adv     = 0;
  logic [31:0] m_ops   = 0;
  logic [31:0] m_stall = 0;
  bit          started = 0;

  function automatic bit model_valid();
    return (mq.size() > 0) && ((adv - mq[0].acc) >= 8);
  endfunction

  always @(posedge clk) begin
    bit   mv, ms;
    exp_t e;
    mv = model_valid();
    ms = mv && !out_ready;
    if (rst) begin
      mq.delete();
      adv     = 0;
      m_ops   = 0;
      m_stall = 0;
      started = 1;
    end else begin
      if (mv && out_ready) m_ops = m_ops + 1;
      if (ms) m_stall = m_stall + 1;
      if (flush) begin
        mq.delete();
      end else if (!ms) begin
        if (mv) void'(mq.pop_front());
        if (in_valid) begin
          e.res = ref_res(in_op, in_a, in_b);
          e.tag = in_tag;
          e.acc = adv;
          mq.push_back(e);
        end
      end
      if (!ms) adv++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit mv;
    if (started) begin
      mv = model_valid();
      chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
      chk("in_ready", {31'b0, in_ready}, {31'b0, !(mv && !out_ready)});
      if (mv) begin
        chk("out_result", out_result, mq[0].res);
        chk("out_tag", {27'b0, out_tag}, {27'b0, mq[0].tag});
      end
`ifdef DIV_PERF_CNT_EN
      chk("perf_ops", perf_ops, m_ops);
      chk("perf_stall", perf_stall, m_stall);
`endif
    end
  end

  // Record delivered results and observed stall cycles.
  logic [31:0] popped[$];
  int          stall_seen = 0;
  always @(negedge clk) begin
    if (out_valid && out_ready) popped.push_back(out_result);
    if (out_valid && !out_ready) stall_seen++;
  end

  // Issue one op (called at posedge+1), then measure its latency and check
  // the literal result. Returns at posedge+1 after the result is consumed.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    int n;
    bit seen;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk({name, "_seen"}, {31'b0, seen}, 32'd1);
    chk({name, "_lat"}, 32'(n), 32'd8);
    chk(name, out_result, exp);
    chk({name, "_tag"}, {27'b0, out_tag}, {27'b0, tag});
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ps0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    ps0 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {27'b0, out_tag}, 32'd0);
    @(posedge clk); #1;

    // Literal directed results
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd3, 32'd14);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd3, 32'd2);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);
    run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1);
    run_op("div_5_0",    2'b00, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF);
    run_op("rem_m5_0",   2'b10, 32'hFFFF_FFFB, 32'd0, 5'd8, 32'hFFFF_FFFB);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0);
    run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF);

    // Back-to-back ops with 3 cycles of backpressure on the first result
    popped.delete();
    stall_seen = 0;
`ifdef DIV_PERF_CNT_EN
    ps0 = perf_stall;
`endif
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_op = 2'b01; in_a = 32'(1000 + i * 37); in_b = 32'(i + 3); in_tag = 5'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_first_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("bp_stall_cycles", 32'(stall_seen), 32'd3);
    chk("bp_count", 32'(popped.size()), 32'd8);
    for (int i = 0; i < popped.size(); i++)
      chk("bp_result", popped[i], 32'((1000 + i * 37) / (i + 3)));
`ifdef DIV_PERF_CNT_EN
    chk("bp_perf_stall_delta", perf_stall - ps0, 32'd3);
`endif

    // Flush with 4 ops in flight; same-cycle request dropped; next op returns at +8
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = 2'b01; in_a = 32'(500 + i); in_b = 32'd3; in_tag = 5'(10 + i);
      @(posedge clk); #1;
    end
    in_op = 2'b01; in_a = 32'd999; in_b = 32'd9; in_tag = 5'd20; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    run_op("post_flush", 2'b01, 32'd81, 32'd9, 5'd21, 32'd9);
    repeat (12) @(posedge clk);
    #1;
    chk("flush_count", 32'(popped.size()), 32'd1);

    // Reset with ops in flight: first op would have appeared after this edge
    popped.delete();
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'd50; in_b = 32'd5; in_tag = 5'd1;
    @(posedge clk); #1;
    in_a = 32'd60; in_tag = 5'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_kill_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("rst_no_results", 32'(popped.size()), 32'd0);
`ifdef DIV_PERF_CNT_EN
    chk("rst_perf_ops", perf_ops, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
`endif

    // Mixed random traffic with random backpressure, checked by the model
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 2'($urandom_range(0, 3));
      in_a      = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       in_b = 32'd0;
        1:       in_b = 32'hFFFF_FFFF;
        2:       in_b = $urandom;
        default: in_b = $urandom >> $urandom_range(8, 30);
      endcase
      in_tag    = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
